// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard: sizes, FSM state
// encoding and the instruction codes the scoreboard treats specially.
package issue_scoreboard_pkg;

  // Register-file and instruction-code sizing shared with decode/execute.
  localparam int NUM_REGS = 32;
  localparam int SEL_W    = 5;
  localparam int CNT_W    = 2;
  localparam int CODE_W   = 6;
  localparam int MAX_PEND = (1 << CNT_W) - 1;

  // Instruction codes from the shared decoded-instruction code space.
  localparam logic [CODE_W-1:0] CODE_FENCE   = 6'h3C;
  localparam logic [CODE_W-1:0] CODE_ECALL   = 6'h3D;
  localparam logic [CODE_W-1:0] CODE_EBREAK  = 6'h3E;
  localparam logic [CODE_W-1:0] CODE_INVALID = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } sb_state_e;

  // Codes that must wait for every outstanding write before entering execute.
  function automatic logic is_serial(input logic [CODE_W-1:0] code);
    return code inside {CODE_FENCE, CODE_ECALL, CODE_EBREAK};
  endfunction

endpackage

// File: rtl/issue_scoreboard_counter_bank.sv
// Per-register pending-write counters. Register 0 is never tracked. An
// increment and a decrement of the same register in one cycle cancel; a
// decrement of a zero counter leaves it at zero and raises underflow.
module pending_counter_bank
  import issue_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_valid,
  input  logic [SEL_W-1:0] inc_sel,
  input  logic             dec_valid,
  input  logic [SEL_W-1:0] dec_sel,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  input  logic [SEL_W-1:0] rd_sel_c,
  output logic [CNT_W-1:0] rd_cnt_a,
  output logic [CNT_W-1:0] rd_cnt_b,
  output logic [CNT_W-1:0] rd_cnt_c,
  output logic             all_zero,
  output logic             underflow
);

  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] dec_hit;

  // One-hot select decode; x0 is masked so it can never count.
  assign inc_hit = inc_valid ? ((ONE_HOT0 << inc_sel) & ~ONE_HOT0) : '0;
  assign dec_hit = dec_valid ? ((ONE_HOT0 << dec_sel) & ~ONE_HOT0) : '0;

  assign rd_cnt_a = cnt_q[rd_sel_a];
  assign rd_cnt_b = cnt_q[rd_sel_b];
  assign rd_cnt_c = cnt_q[rd_sel_c];

  // Next counter values: saturating up/down with same-cycle cancellation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    cnt_d     = cnt_q;
    underflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (inc_hit[r] && !dec_hit[r]) begin
        if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
        else                underflow = 1'b1;
      end
    end
  end

  // Drain detection: true when no register has an outstanding write.
  always_comb begin
    all_zero = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) all_zero = 1'b0;
    end
  end

  // Counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is state, not a data memory: outstanding counts must
      // read zero straight out of reset, so every entry is reset explicitly.
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue scoreboard: tracks outstanding GPR writes, stalls
// on RAW and counter-full hazards, serialises FENCE/ECALL/EBREAK behind a
// drained pipeline, and traps on INVALID until flushed.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_dec_valid,
  output logic              o_dec_ready,
  input  logic [CODE_W-1:0] i_dec_code,
  input  logic [SEL_W-1:0]  i_dec_src1,
  input  logic [SEL_W-1:0]  i_dec_src2,
  input  logic [SEL_W-1:0]  i_dec_dest,
  input  logic              i_dec_wr,
  output logic              o_issue_valid,
  input  logic              i_issue_ready,
  output logic [CODE_W-1:0] o_issue_code,
  output logic [SEL_W-1:0]  o_issue_dest,
  output logic              o_issue_wr,
  input  logic              i_wb_valid,
  input  logic [SEL_W-1:0]  i_wb_sel,
  input  logic              i_flush,
  output logic              o_illegal,
  output logic              o_sb_error
);

  localparam int PW = CNT_W + 1;

  sb_state_e         state_q, state_d;
  logic              hold_valid_q, hold_valid_d;
  logic [CODE_W-1:0] hold_code_q, hold_code_d;
  logic [SEL_W-1:0]  hold_dest_q, hold_dest_d;
  logic              hold_wr_q, hold_wr_d;
  logic              illegal_q, illegal_d;
  logic              sb_error_q, sb_error_d;

  logic [CNT_W-1:0]  cnt_src1, cnt_src2, cnt_dest;
  logic [PW-1:0]     pend_src1, pend_src2, pend_dest;
  logic              all_zero, underflow;
  logic              hold_pend_wr, space, hazard, stall, drained;
  logic              dec_serial, dec_invalid, dec_ready, accept, issue_fire;

  // A held writer counts as pending whether or not it issues this cycle.
  assign hold_pend_wr = hold_valid_q && hold_wr_q && (hold_dest_q != '0);
  assign pend_src1 = PW'(cnt_src1) + PW'(hold_pend_wr && (hold_dest_q == i_dec_src1));
  assign pend_src2 = PW'(cnt_src2) + PW'(hold_pend_wr && (hold_dest_q == i_dec_src2));
  assign pend_dest = PW'(cnt_dest) + PW'(hold_pend_wr && (hold_dest_q == i_dec_dest));

  // Writebacks in the current cycle do not bypass: they clear next cycle.
  assign hazard = ((i_dec_src1 != '0) && (pend_src1 != '0)) ||
                  ((i_dec_src2 != '0) && (pend_src2 != '0));
  assign stall  = i_dec_wr && (i_dec_dest != '0) && (pend_dest >= PW'(MAX_PEND));
  assign space  = !hold_valid_q || i_issue_ready;

  // Drained: nothing outstanding and the hold register empty or leaving
  // without adding a write of its own.
  assign drained = all_zero && (!hold_valid_q || (i_issue_ready && !hold_pend_wr));

  assign dec_serial  = i_dec_valid && is_serial(i_dec_code);
  assign dec_invalid = i_dec_valid && (i_dec_code == CODE_INVALID);
  assign accept      = i_dec_valid && dec_ready;
  assign issue_fire  = hold_valid_q && i_issue_ready && !i_flush;

  pending_counter_bank u_bank (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .inc_valid (issue_fire && hold_wr_q),
    .inc_sel   (hold_dest_q),
    .dec_valid (i_wb_valid),
    .dec_sel   (i_wb_sel),
    .rd_sel_a  (i_dec_src1),
    .rd_sel_b  (i_dec_src2),
    .rd_sel_c  (i_dec_dest),
    .rd_cnt_a  (cnt_src1),
    .rd_cnt_b  (cnt_src2),
    .rd_cnt_c  (cnt_dest),
    .all_zero  (all_zero),
    .underflow (underflow)
  );

  // FSM state register plus hold register and output flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!i_reset_n) begin
      state_q      <= ST_RUN;
      hold_valid_q <= 1'b0;
      hold_code_q  <= '0;
      hold_dest_q  <= '0;
      hold_wr_q    <= 1'b0;
      illegal_q    <= 1'b0;
      sb_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_code_q  <= hold_code_d;
      hold_dest_q  <= hold_dest_d;
      hold_wr_q    <= hold_wr_d;
      illegal_q    <= illegal_d;
      sb_error_q   <= sb_error_d;
    end
  end

  // FSM next state: flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dec_invalid)     state_d = ST_TRAP;
          else if (dec_serial) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (accept && dec_invalid)      state_d = ST_TRAP;
          else if (!i_dec_valid || accept) state_d = ST_RUN;
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM output: decode handshake ready; INVALID is taken despite hazards.
  always_comb begin
    dec_ready = 1'b0;
    if (!i_flush) begin
      case (state_q)
        ST_RUN:   dec_ready = dec_invalid || (space && !hazard && !stall && !dec_serial);
        ST_DRAIN: dec_ready = drained;
        default:  dec_ready = 1'b0;
      endcase
    end
  end

  // Hold register and flag updates: changes only on accept, issue or flush.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_code_d  = hold_code_q;
    hold_dest_d  = hold_dest_q;
    hold_wr_d    = hold_wr_q;
    illegal_d    = accept && dec_invalid;
    sb_error_d   = sb_error_q || underflow;
    if (i_flush) begin
      hold_valid_d = 1'b0;
    end else if (accept && !dec_invalid) begin
      hold_valid_d = 1'b1;
      hold_code_d  = i_dec_code;
      hold_dest_d  = i_dec_dest;
      hold_wr_d    = i_dec_wr;
    end else if (issue_fire) begin
      hold_valid_d = 1'b0;
    end
  end

  // Ready is held low while reset is asserted so every output reads zero.
  assign o_dec_ready   = dec_ready && i_reset_n;
  assign o_issue_valid = hold_valid_q;
  assign o_issue_code  = hold_code_q;
  assign o_issue_dest  = hold_dest_q;
  assign o_issue_wr    = hold_wr_q;
  assign o_illegal     = illegal_q;
  assign o_sb_error    = sb_error_q;

endmodule
